// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core: fetch handshake, next-PC select, EPC/CAUSE/EXL.
// Optional build macro PC_SEQ_INT_EN enables external interrupt entry (int_req) when EXL is clear.
//   state | meaning
//   BOOT  | first cycle after reset, steer PC to RESET_VECTOR
//   FETCH | request instruction at cur_pc, hold PC until imem_ready
//   EXEC  | decode inputs valid, select next PC or take exception
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_4180,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cur_pc,
    input  logic        imem_ready,
    output logic        fetch_req,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] jaddr,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        eret,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        int_req,
    output logic [31:0] new_pc,
    output logic        instr_valid,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        exl
);

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_EXEC} state_e;

    localparam logic [7:0] TO_LIM = 8'(FETCH_TIMEOUT);
    localparam logic [4:0] EXC_ADDR_ERR  = 5'd4;
    localparam logic [4:0] EXC_BUS_ERR   = 5'd6;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  cause_q, cause_d;
    logic        exl_q, exl_d;

    logic [31:0] new_pc_c;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] tgt;
    logic [7:0]  cnt_inc;
    logic        int_take;

`ifdef PC_SEQ_INT_EN
    assign int_take = int_req & ~exl_q;
`else
    logic unused_int_req;
    assign unused_int_req = int_req;
    assign int_take       = 1'b0;
`endif

    assign pc4     = cur_pc + 32'd4;
    assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        exl_d    = exl_q;
        new_pc_c = cur_pc;
        tgt      = pc4;
        case (state_q)
            ST_BOOT: begin
                new_pc_c = RESET_VECTOR;
                cnt_d    = 8'd0;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    cnt_d   = 8'd0;
                    state_d = ST_EXEC;
                end else if (cnt_inc == TO_LIM) begin
                    cnt_d    = 8'd0;
                    epc_d    = cur_pc;
                    cause_d  = EXC_BUS_ERR;
                    exl_d    = 1'b1;
                    new_pc_c = EXC_VECTOR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (exc_req) begin
                    epc_d    = cur_pc;
                    cause_d  = exc_code;
                    exl_d    = 1'b1;
                    new_pc_c = EXC_VECTOR;
                end else if (int_take) begin
                    epc_d    = pc4;
                    cause_d  = 5'd0;
                    exl_d    = 1'b1;
                    new_pc_c = EXC_VECTOR;
                end else if (stall) begin
                    state_d  = ST_EXEC;
                    new_pc_c = cur_pc;
                end else begin
                    if (eret)                   tgt = epc_q;
                    else if (jr)                tgt = jr_target;
                    else if (jump)              tgt = {pc4[31:28], jaddr, 2'b00};
                    else if (branch && branch_taken) tgt = pc4 + br_off;
                    else                        tgt = pc4;
                    // A misaligned control-flow target becomes an address-error exception
                    if (tgt[1:0] != 2'b00) begin
                        epc_d    = cur_pc;
                        cause_d  = EXC_ADDR_ERR;
                        exl_d    = 1'b1;
                        new_pc_c = EXC_VECTOR;
                    end else begin
                        new_pc_c = tgt;
                        if (eret) exl_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_BOOT;
                new_pc_c = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            cnt_q   <= 8'd0;
            epc_q   <= 32'd0;
            cause_q <= 5'd0;
            exl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            exl_q   <= exl_d;
        end
    end

    // Reset overrides the combinational path so the PC register loads the boot vector during rst.
    assign new_pc      = rst ? RESET_VECTOR : new_pc_c;
    assign fetch_req   = ~rst & (state_q == ST_FETCH);
    assign instr_valid = ~rst & (state_q == ST_EXEC);
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign exl         = exl_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the program-counter register of the single-cycle MIPS core.
- Runs a fetch handshake with instruction memory and computes the next PC: sequential, branch, jump, jr, exception vector or eret.
- Maintains EPC, CAUSE and EXL.
- Its new_pc output drives the PC register's next-address input. Whenever the PC must not advance, new_pc equals cur_pc.

Parameters:
- RESET_VECTOR, 32'h0000_3000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address.
- FETCH_TIMEOUT, 15, maximum FETCH cycles without imem_ready before a bus-error exception (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cur_pc  in  32  current value of the PC register.
- imem_ready  in  1  instruction word valid this cycle.
- fetch_req  out  1  fetch request to imem at cur_pc.
- stall  in  1  hazard hold from the datapath.
- branch  in  1  decoded instruction is a conditional branch.
- branch_taken  in  1  comparator result.
- imm16  in  16  branch offset field.
- jump  in  1  j/jal.
- jaddr  in  26  jump index field.
- jr  in  1  jr/jalr.
- jr_target  in  32  register target.
- eret  in  1  decoded eret.
- exc_req  in  1  synchronous exception from datapath.
- exc_code  in  5  code for exc_req.
- int_req  in  1  external interrupt, level.
- new_pc  out  32  next PC, combinational.
- instr_valid  out  1  high in EXEC; the decode inputs are sampled in this cycle.
- epc  out  32  exception PC register.
- cause  out  5  last exception code.
- exl  out  1  exception level; 1 masks interrupts.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- While rst=1, and in the cycle after rst is released:
  - state=BOOT, new_pc=RESET_VECTOR.
  - fetch_req=0, instr_valid=0.
  - epc=0, cause=0, exl=0, timeout counter=0.
- A reset asserted in any state takes effect at the next edge and discards any pending action.
- State BOOT:
  - new_pc=RESET_VECTOR.
  - Next state FETCH.
- State FETCH:
  - fetch_req=1, new_pc=cur_pc.
  - If imem_ready=1: next state EXEC and the counter clears.
  - Otherwise the counter increments. When it reaches FETCH_TIMEOUT, take exception code 6: epc<=cur_pc, new_pc=EXC_VECTOR, next state FETCH, counter clears.
- State EXEC:
  - instr_valid=1.
  - The first matching rule applies, in priority order:
    1. exc_req: epc<=cur_pc, cause<=exc_code, exl<=1, new_pc=EXC_VECTOR.
    2. int_req and exl=0: epc<=cur_pc+4, cause<=0, exl<=1, new_pc=EXC_VECTOR.
    3. stall: new_pc=cur_pc; stay in EXEC.
    4. eret: new_pc=epc, exl<=0.
    5. jr: new_pc=jr_target.
    6. jump: new_pc={pc4[31:28], jaddr, 2'b00}.
    7. branch and branch_taken: new_pc=pc4+(sign-extended imm16<<2).
    8. Otherwise: new_pc=pc4.
  - pc4=cur_pc+4. All arithmetic is 32-bit modulo 2^32, so 0xFFFF_FFFC+4=0.
  - After every rule except stall, the next state is FETCH.
- Misaligned target: if the rule 4–7 target has bits[1:0]≠0, treat it as exception code 4 instead. epc<=cur_pc, cause<=4, exl<=1, new_pc=EXC_VECTOR.
- An exception while exl=1 still enters: epc is overwritten and exl stays 1.
- branch with branch_taken=0 → sequential.
- Decode inputs are ignored outside EXEC.

Optional Feature:
- Macro: PC_SEQ_INT_EN.
- Defined: int_req handling as rule 2.
- Undefined: int_req is ignored, the port remains present, and exl is cleared only by eret or reset.

Test Plan:
- Reset: hold rst 2 cycles, then release with imem_ready=1 → new_pc=0x0000_3000 in BOOT, then FETCH→EXEC; sequential EXEC gives new_pc=0x0000_3004.
- Branch: cur_pc=0x0000_3010, branch=1, branch_taken=1, imm16=0xFFFC → new_pc=0x0000_3004. Same stimulus with branch_taken=0 → 0x0000_3014.
- Jump and jr: cur_pc=0x0000_3000, jump=1, jaddr=0x0000C10 → new_pc=0x0000_3040. jr_target=0x0000_3002 → exception, cause=4, epc=0x0000_3000, new_pc=0x0000_4180.
- Interrupt/eret (with PC_SEQ_INT_EN): int_req at cur_pc=0x0000_3020 → epc=0x0000_3024, exl=1. Reassert int_req → ignored. eret → new_pc=0x0000_3024, exl=0.
- Fetch timeout: imem_ready held 0 for 15 cycles at cur_pc=0x0000_3008 → cause=6, epc=0x0000_3008, new_pc=0x0000_4180.
- Stall vs exception: stall=1 for 3 EXEC cycles → new_pc=cur_pc each cycle. stall=1 with exc_req=1, exc_code=10 → exception taken, cause=10.
